// File: rtl/screen_wipe_engine.sv
// ---------------------------------------------------------------------------
// screen_wipe_engine
//
// Generates a stream of full-span lines that sweep across the frame. Each
// line is one horizontal or one vertical line, and a downstream line drawer
// draws them in turn to clear or fill the screen. Consecutive lines are
// STEP pixels apart. The last step is clamped so that the far edge of the
// frame is always drawn.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   start       one-cycle launch request; sampled only while idle
//   mode        sweep direction, latched on start:
//                 00 top->bottom, 01 bottom->top,
//                 10 left->right, 11 right->left
//   color_in    wipe colour, latched on start
//   abort       synchronous cancel of the wipe in progress
//   line_ready  the drawer accepts the presented line this cycle
//   line_valid  x0/y0/x1/y1/color hold a valid line
//   x0, x1      line endpoint x coordinates
//   y0, y1      line endpoint y coordinates
//   color       latched wipe colour
//   busy        high while lines are being issued
//   done        one-cycle pulse after the last line has been accepted
// ---------------------------------------------------------------------------
module screen_wipe_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int STEP  = 1,
    parameter int CW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] color_in,
    input  logic          abort,
    input  logic          line_ready,
    output logic          line_valid,
    output logic [XW-1:0] x0,
    output logic [XW-1:0] x1,
    output logic [YW-1:0] y0,
    output logic [YW-1:0] y1,
    output logic [CW-1:0] color,
    output logic          busy,
    output logic          done
);

    // The position counter is one bit wider than either coordinate. This
    // lets pos+STEP be compared against the end coordinate without
    // wrapping around.
    localparam int PW = ((XW > YW) ? XW : YW) + 1;

    localparam logic [PW-1:0] X_END  = PW'(H_RES - 1);
    localparam logic [PW-1:0] Y_END  = PW'(V_RES - 1);
    localparam logic [PW-1:0] STEP_P = PW'(STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_reg;
    logic [1:0]    mode_reg;
    logic [CW-1:0] color_reg;
    logic [PW-1:0] pos_reg;
    logic          line_valid_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [XW-1:0] x0_reg;
    logic [XW-1:0] x1_reg;
    logic [YW-1:0] y0_reg;
    logic [YW-1:0] y1_reg;

    logic [PW-1:0] end_pos;
    logic [PW-1:0] start_pos;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_next;
    logic [PW-1:0] coord_pos;
    logic [1:0]    coord_mode;
    logic          last_line;
    logic          xfer;
    logic [XW-1:0] x0_next;
    logic [XW-1:0] x1_next;
    logic [YW-1:0] y0_next;
    logic [YW-1:0] y1_next;

    always_comb begin
        end_pos   = mode_reg[1] ? X_END : Y_END;
        last_line = mode_reg[0] ? (pos_reg == '0) : (pos_reg == end_pos);
        pos_inc   = pos_reg + STEP_P;

        // Clamp the step at the frame edge so that the final line lands
        // exactly on the boundary.
        if (mode_reg[0]) begin
            pos_next = (pos_reg < STEP_P) ? '0 : (pos_reg - STEP_P);
        end else begin
            pos_next = (pos_inc > end_pos) ? end_pos : pos_inc;
        end

        case (mode)
            2'b01:   start_pos = Y_END;
            2'b11:   start_pos = X_END;
            default: start_pos = '0;
        endcase

        // While idle, the coordinates being loaded come from the launch
        // inputs. Otherwise they come from the advanced position under
        // the latched mode.
        if (state_reg == S_IDLE) begin
            coord_pos  = start_pos;
            coord_mode = mode;
        end else begin
            coord_pos  = pos_next;
            coord_mode = mode_reg;
        end

        if (coord_mode[1]) begin
            x0_next = XW'(coord_pos);
            x1_next = XW'(coord_pos);
            y0_next = '0;
            y1_next = YW'(Y_END);
        end else begin
            x0_next = '0;
            x1_next = XW'(X_END);
            y0_next = YW'(coord_pos);
            y1_next = YW'(coord_pos);
        end

        xfer = line_valid_reg && line_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            mode_reg       <= 2'b00;
            color_reg      <= '0;
            pos_reg        <= '0;
            line_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            x0_reg         <= '0;
            x1_reg         <= '0;
            y0_reg         <= '0;
            y1_reg         <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg       <= mode;
                        color_reg      <= color_in;
                        pos_reg        <= start_pos;
                        x0_reg         <= x0_next;
                        x1_reg         <= x1_next;
                        y0_reg         <= y0_next;
                        y1_reg         <= y1_next;
                        line_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Abort takes priority over a coincident transfer. That
                    // line has been handed over, but nothing follows it.
                    if (abort) begin
                        line_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= S_IDLE;
                    end else if (xfer) begin
                        if (last_line) begin
                            line_valid_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                            state_reg      <= S_DONE;
                        end else begin
                            pos_reg <= pos_next;
                            x0_reg  <= x0_next;
                            x1_reg  <= x1_next;
                            y0_reg  <= y0_next;
                            y1_reg  <= y1_next;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign line_valid = line_valid_reg;
    assign x0         = x0_reg;
    assign x1         = x1_reg;
    assign y0         = y0_reg;
    assign y1         = y1_reg;
    assign color      = color_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_screen_wipe_engine.sv
// ---------------------------------------------------------------------------
// Testbench for screen_wipe_engine.
//
// Two instances share the same stimulus: dut_a uses STEP=1 and dut_b uses
// STEP=4. Each directed step checks one of the two instances. The
// expected line sequence is built by a small sweep model and pushed to a
// queue at launch. Each accepted line is popped from that queue and
// compared.
// ---------------------------------------------------------------------------
module tb_screen_wipe_engine;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] color_in;
    logic          abort;
    logic          line_ready;

    logic          lv_a, busy_a, done_a;
    logic [XW-1:0] x0_a, x1_a;
    logic [YW-1:0] y0_a, y1_a;
    logic [CW-1:0] col_a;
    logic          lv_b, busy_b, done_b;
    logic [XW-1:0] x0_b, x1_b;
    logic [YW-1:0] y0_b, y1_b;
    logic [CW-1:0] col_b;

    always #5 clk = ~clk;

    screen_wipe_engine #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .STEP(1), .CW(CW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .color_in(color_in),
        .abort(abort), .line_ready(line_ready), .line_valid(lv_a),
        .x0(x0_a), .x1(x1_a), .y0(y0_a), .y1(y1_a), .color(col_a),
        .busy(busy_a), .done(done_a)
    );

    screen_wipe_engine #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .STEP(4), .CW(CW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .color_in(color_in),
        .abort(abort), .line_ready(line_ready), .line_valid(lv_b),
        .x0(x0_b), .x1(x1_b), .y0(y0_b), .y1(y1_b), .color(col_b),
        .busy(busy_b), .done(done_b)
    );

    int          errors = 0;
    int          checks = 0;
    int          n;
    logic [38:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [38:0] cur_line(input int sel);
        if (sel != 0) return {x0_b, y0_b, x1_b, y1_b, col_b};
        return {x0_a, y0_a, x1_a, y1_a, col_a};
    endfunction

    // {line_valid, busy, done}
    function automatic logic [2:0] cur_st(input int sel);
        if (sel != 0) return {lv_b, busy_b, done_b};
        return {lv_a, busy_a, done_a};
    endfunction

    function automatic logic [38:0] mk_line(input logic [1:0] m, input int p, input logic c);
        if (m[1]) return {10'(p), 9'(0), 10'(p), 9'(V - 1), c};
        return {10'(0), 9'(p), 10'(H - 1), 9'(p), c};
    endfunction

    function automatic void push_wipe(input int step, input logic [1:0] m, input logic c);
        int span;
        int p;
        span = m[1] ? H : V;
        p    = m[0] ? span - 1 : 0;
        for (int k = 0; k < 2000; k++) begin
            exp_q.push_back(mk_line(m, p, c));
            if (m[0] ? (p == 0) : (p == span - 1)) break;
            if (m[0]) p = (p - step < 0) ? 0 : p - step;
            else      p = (p + step > span - 1) ? span - 1 : p + step;
        end
    endfunction

    // Called at posedge+1. The start pulse is seen at the next edge.
    task automatic begin_wipe(input int sel, input logic [1:0] m, input logic c);
        exp_q.delete();
        push_wipe((sel != 0) ? 4 : 1, m, c);
        start    = 1'b1;
        mode     = m;
        color_in = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // rmode 0: line_ready always high. rmode 1: line_ready follows 1-0-0-1.
    // abort_n > 0: abort is raised during the transfer of line abort_n.
    // restart: a conflicting start is pulsed mid-wipe.
    task automatic run_wipe(input int sel, input int rmode, input int abort_n,
                            input bit restart, input logic [1:0] m, input logic c,
                            output int ntx);
        int          cyc;
        bit          last_prev, aborted_prev, stalled, fin, ab;
        logic [38:0] held, got;
        logic [2:0]  st;
        ntx = 0; cyc = 0; last_prev = 0; aborted_prev = 0; stalled = 0; fin = 0;
        held = '0;
        while (!fin) begin
            line_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            st = cur_st(sel);
            ab = (abort_n > 0) && (ntx == abort_n - 1) && line_ready && st[2];
            abort = ab;
            if (restart && cyc == 5) begin
                start = 1'b1; mode = ~m; color_in = ~c;
            end else begin
                start = 1'b0; mode = m; color_in = c;
            end
            @(negedge clk);
            st  = cur_st(sel);
            got = cur_line(sel);
            chk("done_pulse", 64'(st[0]), 64'(last_prev));
            if (cyc == 0) chk("start_latency_valid", 64'(st[2]), 64'(1));
            if (last_prev || aborted_prev) begin
                chk("valid_low_at_end", 64'(st[2]), 64'(0));
                chk("busy_low_at_end", 64'(st[1]), 64'(0));
                fin = 1;
            end else begin
                chk("valid_in_wipe", 64'(st[2]), 64'(1));
                chk("busy_in_wipe", 64'(st[1]), 64'(1));
                if (stalled) chk("stall_hold", 64'(got), 64'(held));
                if (st[2] && line_ready) begin
                    ntx++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_line: observed=%0h expected=none", got);
                    end else begin
                        chk($sformatf("line%0d", ntx), 64'(got), 64'(exp_q.pop_front()));
                        if (exp_q.size() == 0) last_prev = 1;
                    end
                    if (ab) aborted_prev = 1;
                end
                stalled = st[2] && !line_ready;
                held    = got;
            end
            @(posedge clk); #1;
            cyc++;
            if (!fin && cyc >= 4000) begin
                checks++; errors++;
                $display("FAIL timeout: observed=%0d cycles expected=completion", cyc);
                fin = 1;
            end
        end
        abort = 1'b0; start = 1'b0; line_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic idle_check(input int sel, input int cycles, input string tag);
        logic [2:0] st;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            st = cur_st(sel);
            chk(tag, 64'(st), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; line_ready = 1'b1;
        mode = 2'b00; color_in = '0;
        #12;
        chk("reset_status", 64'(cur_st(0)), 64'(0));
        chk("reset_line", 64'(cur_line(0)), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        idle_check(0, 2, "idle_after_reset");

        // Mode 00, STEP 1, ready always high: 480 lines.
        begin_wipe(0, 2'b00, 1'b1);
        run_wipe(0, 0, 0, 1'b0, 2'b00, 1'b1, n);
        chk("count_mode00", 64'(n), 64'(480));
        idle_check(0, 2, "idle_after_mode00");

        // Mode 11, STEP 4: 161 lines, with the last one clamped to x=0.
        begin_wipe(1, 2'b11, 1'b0);
        run_wipe(1, 0, 0, 1'b0, 2'b11, 1'b0, n);
        chk("count_mode11_step4", 64'(n), 64'(161));
        abort = 1'b1;              // dut_a is still running; cancel it
        @(posedge clk); #1;
        abort = 1'b0;
        idle_check(0, 1, "idle_a_after_abort");
        idle_check(1, 1, "idle_b_after_mode11");

        // Mode 01 with line_ready stalling.
        begin_wipe(0, 2'b01, 1'b1);
        run_wipe(0, 1, 0, 1'b0, 2'b01, 1'b1, n);
        chk("count_mode01_stall", 64'(n), 64'(480));

        // Mode 10 aborted during the 10th transfer: no done.
        begin_wipe(0, 2'b10, 1'b0);
        run_wipe(0, 0, 10, 1'b0, 2'b10, 1'b0, n);
        chk("count_abort", 64'(n), 64'(10));
        idle_check(0, 3, "no_done_after_abort");

        // New start after abort, with a conflicting start mid-wipe.
        begin_wipe(0, 2'b10, 1'b1);
        run_wipe(0, 0, 0, 1'b1, 2'b10, 1'b1, n);
        chk("count_restart_ignored", 64'(n), 64'(640));
        idle_check(0, 2, "idle_after_restart");

        // Asynchronous reset mid-wipe.
        begin_wipe(0, 2'b00, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_status", 64'(cur_st(0)), 64'(0));
        chk("async_reset_line", 64'(cur_line(0)), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        idle_check(0, 4, "idle_after_async_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
